// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address, and fills the IF/ID register.
// Defining IFETCH_PERF_CNT_EN adds saturating fetch and stall counters.
module if_stage #(
  parameter int                 PC_W       = 64,
  parameter int                 INSTR_W    = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR  = 32'h0000_0000,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 32'hFFFF_FFFF,
  parameter int                 CNT_W      = 32
) (
  input  logic               CLK,
  input  logic               resetl,
  input  logic [PC_W-1:0]    startpc,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [PC_W-1:0]    currentpc,
  output logic [INSTR_W-1:0] ifid_instruction,
  output logic [PC_W-1:0]    ifid_pc,
  output logic               ifid_valid,
`ifdef IFETCH_PERF_CNT_EN
  output logic [CNT_W-1:0]   fetch_count,
  output logic [CNT_W-1:0]   stall_count,
`endif
  output logic               halted
);

  // state  | meaning
  // S_LOAD | first edge after reset: load startpc, IF/ID empty
  // S_RUN  | fetching; redirect > stall > sequential fetch
  // S_HALT | halt word seen; PC frozen until a redirect arrives
  typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_t;

  state_t               state_q;
  logic [PC_W-1:0]      pc_q;
  logic [INSTR_W-1:0]   ifid_instr_q;
  logic [PC_W-1:0]      ifid_pc_q;
  logic                 ifid_valid_q;
  logic                 halted_q;
  logic [PC_W-1:0]      redir_pc_d;
  logic                 unused_redirect_lsb;

  assign redir_pc_d          = {redirect_pc[PC_W-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q      <= S_LOAD;
      pc_q         <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          pc_q         <= startpc;
          ifid_instr_q <= NOP_INSTR;
          ifid_pc_q    <= '0;
          ifid_valid_q <= 1'b0;
          state_q      <= S_RUN;
        end
        S_RUN: begin
          if (redirect) begin
            pc_q         <= redir_pc_d;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
          end else if (!stall) begin
            ifid_instr_q <= imem_data;
            ifid_pc_q    <= pc_q;
            ifid_valid_q <= 1'b1;
            // The halt word is kept valid so decode sees it; the PC parks on it.
            if (imem_data == HALT_INSTR) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_q + PC_W'(4);
            end
          end
        end
        S_HALT: begin
          if (redirect) begin
            pc_q         <= redir_pc_d;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            state_q      <= S_RUN;
          end else if (!stall) begin
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_LOAD;
        end
      endcase
    end
  end

  assign imem_addr        = pc_q;
  assign currentpc        = pc_q;
  assign ifid_instruction = ifid_instr_q;
  assign ifid_pc          = ifid_pc_q;
  assign ifid_valid       = ifid_valid_q;
  assign halted           = halted_q;

`ifdef IFETCH_PERF_CNT_EN
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             fetch_inc, stall_inc;

  assign fetch_inc = (state_q == S_RUN) && !redirect && !stall;
  assign stall_inc = (state_q == S_RUN) && !redirect && stall;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fetch_inc && !(&fetch_cnt_q)) fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
    if (stall_inc && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule
